// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module  : sram_controller
// Brief   : Multi-cycle CPU-request to 16-bit asynchronous SRAM pin sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module sram_controller #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        be,
    output logic              busy,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] addresses,
    output logic [4:0]        control_mem,
    inout  wire  [DATA_W-1:0] data
);

    localparam int                 c_WAIT     = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int                 c_CNT_W    = (c_WAIT > 1) ? $clog2(c_WAIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(c_WAIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_be;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_sel;
    logic                w_ce_n;
    logic                w_oe_n;
    logic                w_we_n;
    logic                w_ub_n;
    logic                w_lb_n;
    logic                w_drive;
    logic                w_last;

    assign w_sel  = |r_be;
    assign w_last = (r_state == S_ACCESS) && (r_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (r_cnt == '0) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Request fields are captured only on acceptance, so bus-side inputs may wander while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= 2'b00;
        end else if (r_state == S_IDLE && req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_be    <= be;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 r_cnt <= '0;
        else if (r_state == S_SETUP)               r_cnt <= c_CNT_LOAD;
        else if (r_state == S_ACCESS && r_cnt != '0) r_cnt <= r_cnt - c_CNT_ONE;
    end

    // With no byte selected the chip is never enabled, so there is nothing valid to sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                       r_rdata <= '0;
        else if (w_last && !r_we && w_sel) r_rdata <= data;
    end

    always_comb begin
        w_ce_n  = 1'b1;
        w_oe_n  = 1'b1;
        w_we_n  = 1'b1;
        w_ub_n  = 1'b1;
        w_lb_n  = 1'b1;
        w_drive = 1'b0;
        case (r_state)
            S_SETUP: begin
                w_ce_n  = ~w_sel;
                w_oe_n  = r_we | ~w_sel;
                w_ub_n  = ~r_be[1];
                w_lb_n  = ~r_be[0];
                w_drive = r_we;
            end
            S_ACCESS: begin
                w_ce_n  = ~w_sel;
                w_oe_n  = r_we | ~w_sel;
                w_we_n  = ~(r_we & w_sel);
                w_ub_n  = ~r_be[1];
                w_lb_n  = ~r_be[0];
                w_drive = r_we;
            end
            S_DONE: begin
                w_ub_n  = ~r_be[1];
                w_lb_n  = ~r_be[0];
                w_drive = r_we;
            end
            default: ;
        endcase
    end

    assign data        = w_drive ? r_wdata : {DATA_W{1'bz}};
    assign control_mem = {w_ce_n, w_oe_n, w_we_n, w_ub_n, w_lb_n};
    assign addresses   = r_addr;
    assign rdata       = r_rdata;
    assign busy        = (r_state != S_IDLE);
    assign ready       = (r_state == S_DONE);

endmodule
`default_nettype wire
